// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war score keeper: FSM states and the seven-segment lookup.
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    HOLD    = 2'd1,
    RESTART = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Active-low segments, bit 6 = g down to bit 0 = a; indexed by digit 0..7.
  localparam logic [6:0] SEG7_LUT [8] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
  };

endpackage

// File: rtl/score_keeper_if.sv
// Round-result inputs and score/display outputs of the score keeper.
interface score_keeper_if;
  logic       win_l;
  logic       win_r;
  logic [2:0] score_l;
  logic [2:0] score_r;
  logic       round_reset;
  logic       match_over;
  logic [6:0] hex_l;
  logic [6:0] hex_r;

  modport master (
    output win_l, win_r,
    input  score_l, score_r, round_reset, match_over, hex_l, hex_r
  );

  modport slave (
    input  win_l, win_r,
    output score_l, score_r, round_reset, match_over, hex_l, hex_r
  );
endinterface

// File: rtl/seg7_digit.sv
// Combinational 3-bit digit to active-low seven-segment pattern.
module seg7_digit
  import tug_pkg::*;
(
  input  logic [2:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_LUT[digit_i];

endmodule

// File: rtl/score_keeper.sv
// Counts round wins, holds each result for HOLD_CYCLES, then pulses round_reset or ends the match.
// All status outputs are registers; displays are decoded from the registered scores.
module score_keeper
  import tug_pkg::*;
#(
  parameter int WIN_ROUNDS  = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  localparam int            CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [2:0]    WIN_Q     = 3'(WIN_ROUNDS);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_e        state_q;
  logic [2:0]    score_l_q, score_r_q;
  logic [2:0]    score_l_d, score_r_d;
  logic [CW-1:0] cnt_q;
  logic          round_reset_q;
  logic          match_over_q;
  logic          round_won;

  // Saturating increments: a score never passes WIN_ROUNDS.
  assign score_l_d = (score_l_q == WIN_Q) ? score_l_q : score_l_q + 3'd1;
  assign score_r_d = (score_r_q == WIN_Q) ? score_r_q : score_r_q + 3'd1;
  assign round_won = (score_l_q == WIN_Q) || (score_r_q == WIN_Q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      score_l_q     <= 3'd0;
      score_r_q     <= 3'd0;
      cnt_q         <= '0;
      round_reset_q <= 1'b0;
      match_over_q  <= 1'b0;
    end else begin
      round_reset_q <= 1'b0;
      case (state_q)
        PLAY: begin
          // A simultaneous win on both sides is a tie and is discarded.
          if (bus.win_l ^ bus.win_r) begin
            if (bus.win_l) score_l_q <= score_l_d;
            else           score_r_q <= score_r_d;
            cnt_q   <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == HOLD_LAST) begin
            if (round_won) begin
              state_q      <= DONE;
              match_over_q <= 1'b1;
            end else begin
              state_q       <= RESTART;
              round_reset_q <= 1'b1;
            end
          end
        end
        RESTART: state_q <= PLAY;
        DONE:    state_q <= DONE;
        default: state_q <= PLAY;
      endcase
    end
  end

  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.round_reset = round_reset_q;
  assign bus.match_over  = match_over_q;

  seg7_digit u_seg_l (.digit_i(score_l_q), .seg_o(bus.hex_l));
  seg7_digit u_seg_r (.digit_i(score_r_q), .seg_o(bus.hex_r));

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter WIN_ROUNDS, default 7: rounds needed to win the match; legal range 1..7.
REQ-002 Parameter HOLD_CYCLES, default 4: cycles the round result is held before the playfield restarts; legal range 1..2^26; board build uses 25_000_000.
REQ-003 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port win_l, input, 1: one-cycle pulse, left player won the current round; driven by the upstream winner stage.
REQ-006 Port win_r, input, 1: one-cycle pulse, right player won the current round.
REQ-007 Port score_l, output, 3: left player's round count.
REQ-008 Port score_r, output, 3: right player's round count.
REQ-009 Port round_reset, output, 1: one-cycle pulse that restarts the light chain; ORed with the switch reset at top level.
REQ-010 Port match_over, output, 1: high while a player has reached WIN_ROUNDS.
REQ-011 Port hex_l, output, 7: active-low seven-segment pattern of score_l.
REQ-012 Port hex_r, output, 7: active-low seven-segment pattern of score_r.

Function
REQ-013 The FSM SHALL have exactly four states: PLAY, HOLD, RESTART and DONE.
REQ-014 In PLAY, if edge k samples win_l=1 and win_r=0, score_l SHALL increment by 1 at edge k and the state SHALL become HOLD; win_r is handled symmetrically.
REQ-015 In PLAY, if win_l=1 and win_r=1 on the same edge, neither score SHALL change and the state SHALL remain PLAY.
REQ-016 win_l and win_r SHALL be ignored in the HOLD, RESTART and DONE states.
REQ-017 A hold counter SHALL clear on entry to HOLD and count edges k+1 through k+HOLD_CYCLES; at edge k+HOLD_CYCLES the state SHALL go to DONE if either score equals WIN_ROUNDS, otherwise to RESTART.
REQ-018 In RESTART, round_reset SHALL be 1 for exactly one cycle (edge k+HOLD_CYCLES to edge k+HOLD_CYCLES+1), after which the state SHALL be PLAY.
REQ-019 round_reset SHALL be 0 in every state other than RESTART; DONE SHALL NOT assert round_reset.
REQ-020 match_over SHALL be 1 exactly when the state is DONE; DONE SHALL be held, with scores frozen, until reset.
REQ-021 Scores SHALL never exceed WIN_ROUNDS and SHALL never wrap.
REQ-022 hex_l and hex_r SHALL be combinational decodes of the registered scores, visible the same cycle as the score.
REQ-023 Active-low seven-segment patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-024 All registered outputs SHALL be glitch-free register outputs; round_reset SHALL be decoded from a registered state.

Reset
REQ-025 While reset=1 at an edge: state=PLAY, score_l=score_r=0, hold counter=0, round_reset=0, match_over=0, hex_l=hex_r=1000000.
REQ-026 Reset SHALL take priority over win_l and win_r on the same edge, and SHALL abort HOLD, RESTART or DONE with no round_reset pulse.

Structure
REQ-027 The state enum and the seven-segment constant table SHALL live in shared package tug_pkg.
REQ-028 One sub-module, seg7_digit (3-bit score to 7-bit active-low pattern, combinational), SHALL be instantiated twice.
REQ-029 The hold counter width SHALL be $clog2(HOLD_CYCLES+1).

Verification
REQ-030 Scenario 1 (HOLD_CYCLES=4): reset, then win_l at edge 0 -> score_l=1 and hex_l=1111001 after edge 0; round_reset high between edges 4 and 5; PLAY after edge 5.
REQ-031 Scenario 2: win_l and win_r asserted on the same edge in PLAY -> scores stay 0/0, no round_reset pulse, state remains PLAY.
REQ-032 Scenario 3: win_r pulses during HOLD -> score_r unchanged and exactly one round_reset pulse per counted round.
REQ-033 Scenario 4 (WIN_ROUNDS=3): three win_l rounds -> score_l=3 and hex_l=0110000; match_over=1 at edge k+4 after the third win; no round_reset pulse; further wins ignored.
REQ-034 Scenario 5: reset asserted mid-HOLD with score_r=2 -> all outputs return to their reset values at that edge and no round_reset pulse occurs.
